// File: rtl/counter_pkg.sv
// Shared encodings for the counter sequencer: counter MODO codes, FSM states
// and default widths.
package counter_pkg;

  localparam int CNT_W_DEF = 4;
  localparam int LEN_W_DEF = 8;

  localparam logic [1:0] MODO_UP    = 2'b00;
  localparam logic [1:0] MODO_DOWN  = 2'b01;
  localparam logic [1:0] MODO_DOWN3 = 2'b10;
  localparam logic [1:0] MODO_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_RUN    = 2'b10,
    ST_FINISH = 2'b11
  } seq_state_t;

  // MODO_LOAD is reserved for the sequencer itself, so it is not a legal run mode.
  function automatic logic mode_is_legal(input logic [1:0] mode);
    return mode != MODO_LOAD;
  endfunction

endpackage

// File: rtl/counter_sequencer_wrap_tally.sv
// Counts counter RCO pulses that belong to RUN edges, saturating at all-ones.
module wrap_tally
  import counter_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             run,
  input  logic             rco,
  output logic [LEN_W-1:0] wraps
);

  logic run_d;

  // RCO reports the previous edge, so only pulses one cycle after RUN count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_d <= 1'b0;
      wraps <= '0;
    end else begin
      run_d <= run;
      if (clr) begin
        wraps <= '0;
      end else if (run_d && rco && (wraps != {LEN_W{1'b1}})) begin
        wraps <= wraps + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven controller for the 4-bit up/down/load counter: loads START,
// applies exactly LEN counting edges, then reports FINAL_Q, WRAPS and DONE.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_MODE,
  input  logic [CNT_W-1:0] CMD_START,
  input  logic [LEN_W-1:0] CMD_LEN,
  output logic             ENB,
  output logic [1:0]       MODO,
  output logic [CNT_W-1:0] D,
  input  logic [CNT_W-1:0] Q,
  input  logic             RCO,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [CNT_W-1:0] FINAL_Q,
  output logic [LEN_W-1:0] WRAPS,
  output seq_state_t       STATE
);

  // Handshake: a command transfers on a rising edge where CMD_VALID and
  // CMD_READY are both high; CMD_READY is high only in IDLE, and the source
  // must hold CMD_* stable until that edge.

  seq_state_t       state;
  logic [1:0]       mode_q;
  logic [LEN_W-1:0] remaining;
  logic             accept_ok;

  assign STATE     = state;
  assign accept_ok = (state == ST_IDLE) && CMD_VALID && CMD_READY &&
                     mode_is_legal(CMD_MODE);

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state     <= ST_IDLE;
      mode_q    <= MODO_UP;
      remaining <= '0;
      CMD_READY <= 1'b0;
      ENB       <= 1'b0;
      MODO      <= MODO_UP;
      D         <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      FINAL_Q   <= '0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        ST_IDLE: begin
          CMD_READY <= 1'b1;
          ENB       <= 1'b0;
          MODO      <= MODO_UP;
          if (CMD_VALID && CMD_READY) begin
            if (!mode_is_legal(CMD_MODE)) begin
              ERR <= 1'b1;
            end else begin
              state     <= ST_LOAD;
              mode_q    <= CMD_MODE;
              remaining <= CMD_LEN;
              CMD_READY <= 1'b0;
              BUSY      <= 1'b1;
              ENB       <= 1'b1;
              MODO      <= MODO_LOAD;
              D         <= CMD_START;
            end
          end
        end
        ST_LOAD: begin
          if (remaining == '0) begin
            state <= ST_FINISH;
            ENB   <= 1'b0;
            MODO  <= MODO_UP;
          end else begin
            state <= ST_RUN;
            MODO  <= mode_q;
          end
        end
        ST_RUN: begin
          remaining <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state <= ST_FINISH;
            ENB   <= 1'b0;
            MODO  <= MODO_UP;
          end
        end
        ST_FINISH: begin
          // Q already reflects the last RUN edge here.
          FINAL_Q   <= Q;
          DONE      <= 1'b1;
          BUSY      <= 1'b0;
          CMD_READY <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  wrap_tally #(.LEN_W(LEN_W)) u_wrap_tally (
    .clk   (CLK),
    .rst_n (RESET_L),
    .clr   (accept_ok),
    .run   (state == ST_RUN),
    .rco   (RCO),
    .wraps (WRAPS)
  );

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer driving a behavioural 4-bit up/down/load counter;
// results are predicted arithmetically from mode, start and length.
module tb_counter_sequencer;
  import counter_pkg::*;

  localparam int CW = 4;
  localparam int LW = 8;

  logic          CLK = 1'b0;
  logic          RESET_L;
  logic          CMD_VALID;
  logic          CMD_READY;
  logic [1:0]    CMD_MODE;
  logic [CW-1:0] CMD_START;
  logic [LW-1:0] CMD_LEN;
  logic          ENB;
  logic [1:0]    MODO;
  logic [CW-1:0] D;
  logic [CW-1:0] Q;
  logic          RCO;
  logic          BUSY;
  logic          DONE;
  logic          ERR;
  logic [CW-1:0] FINAL_Q;
  logic [LW-1:0] WRAPS;
  seq_state_t    STATE;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];
  logic [11:0] last_res = '0;

  // ---------------- clock / reset / counter ----------------
  always #5 CLK = ~CLK;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      Q   <= '0;
      RCO <= 1'b0;
    end else if (!ENB) begin
      RCO <= 1'b0;
    end else begin
      case (MODO)
        2'b00: begin Q <= Q + 4'd1; RCO <= (Q == 4'd15); end
        2'b01: begin Q <= Q - 4'd1; RCO <= (Q == 4'd0); end
        2'b10: begin Q <= Q - 4'd3; RCO <= (Q < 4'd3); end
        default: begin Q <= D; RCO <= 1'b0; end
      endcase
    end
  end

  counter_sequencer #(.CNT_W(CW), .LEN_W(LW)) dut (
    .CLK       (CLK),
    .RESET_L   (RESET_L),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_MODE  (CMD_MODE),
    .CMD_START (CMD_START),
    .CMD_LEN   (CMD_LEN),
    .ENB       (ENB),
    .MODO      (MODO),
    .D         (D),
    .Q         (Q),
    .RCO       (RCO),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR),
    .FINAL_Q   (FINAL_Q),
    .WRAPS     (WRAPS),
    .STATE     (STATE)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Final value and wrap count from plain arithmetic over the whole run.
  function automatic logic [11:0] model(input int mode, input int start, input int len);
    int total, fq, w, s;
    if (mode == 0) begin
      total = start + len;
      fq    = total % 16;
    end else begin
      s     = (mode == 1) ? 1 : 3;
      total = (15 - start) + len * s;
      fq    = 15 - (total % 16);
    end
    w = total / 16;
    if (w > 255) w = 255;
    return {8'(w), 4'(fq)};
  endfunction

  // ---------------- driver tasks ----------------
  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic send_cmd(input int mode, input int start, input int len, output int waited);
    CMD_MODE  = 2'(mode);
    CMD_START = 4'(start);
    CMD_LEN   = 8'(len);
    CMD_VALID = 1'b1;
    waited = 0;
    while (!CMD_READY && waited < 50) begin
      @(posedge CLK); #1;
      waited++;
    end
    if (waited >= 50) check("ready_timeout", 32'(waited), 32'd0);
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic do_run(input int mode, input int start, input int len,
                        input bit noise, input bit chained);
    int waited, c, enb_n, bad_n;
    bit done_seen;
    logic [11:0] e;
    exp_q.push_back(model(mode, start, len));
    send_cmd(mode, start, len, waited);
    if (chained) check("chain_accept_wait", 32'(waited), 32'd0);
    check("load_enb", 32'(ENB), 32'd1);
    check("load_modo", 32'(MODO), 32'(MODO_LOAD));
    check("load_d", 32'(D), 32'(start));
    check("load_busy", 32'(BUSY), 32'd1);
    check("load_ready", 32'(CMD_READY), 32'd0);
    c = 0; enb_n = 0; bad_n = 0; done_seen = 0;
    while (!done_seen && c < len + 8) begin
      @(negedge CLK);
      if (noise) begin
        CMD_VALID = ENB ? 1'($urandom_range(0, 1)) : 1'b0;
        CMD_MODE  = 2'($urandom_range(0, 3));
        CMD_START = 4'($urandom_range(0, 15));
        CMD_LEN   = 8'($urandom_range(0, 255));
      end
      @(posedge CLK); #1;
      c++;
      if (ENB) begin
        enb_n++;
        if (MODO != 2'(mode)) bad_n++;
      end
      if (DONE) done_seen = 1;
    end
    CMD_VALID = 1'b0;
    check("done_seen", 32'(done_seen), 32'd1);
    check("latency", 32'(c), 32'(len + 2));
    check("enb_cycles", 32'(enb_n), 32'(len));
    check("run_modo_bad", 32'(bad_n), 32'd0);
    check("done_busy", 32'(BUSY), 32'd0);
    check("done_ready", 32'(CMD_READY), 32'd1);
    e = exp_q.pop_front();
    check("final_q", 32'(FINAL_Q), 32'(e[3:0]));
    check("wraps", 32'(WRAPS), 32'(e[11:4]));
    last_res = e;
  endtask

  task automatic idle_cycle();
    @(posedge CLK); #1;
    check("idle_done", 32'(DONE), 32'd0);
    check("idle_err", 32'(ERR), 32'd0);
    check("idle_enb", 32'(ENB), 32'd0);
  endtask

  task automatic do_illegal(input int start, input int len);
    int waited;
    send_cmd(3, start, len, waited);
    check("err_pulse", 32'(ERR), 32'd1);
    check("err_enb", 32'(ENB), 32'd0);
    check("err_ready", 32'(CMD_READY), 32'd1);
    check("err_busy", 32'(BUSY), 32'd0);
    idle_cycle();
    check("err_final_q", 32'(FINAL_Q), 32'(last_res[3:0]));
    check("err_wraps", 32'(WRAPS), 32'(last_res[11:4]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited, mode;
    RESET_L   = 1'b0;
    CMD_VALID = 1'b0;
    CMD_MODE  = 2'b00;
    CMD_START = '0;
    CMD_LEN   = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ready", 32'(CMD_READY), 32'd0);
    check("rst_enb", 32'(ENB), 32'd0);
    check("rst_modo", 32'(MODO), 32'd0);
    check("rst_d", 32'(D), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_final_q", 32'(FINAL_Q), 32'd0);
    check("rst_wraps", 32'(WRAPS), 32'd0);
    @(negedge CLK);
    RESET_L = 1'b1;
    @(posedge CLK); #1;
    check("rel_ready", 32'(CMD_READY), 32'd1);
    check("rel_state", 32'(STATE), 32'(ST_IDLE));

    do_run(0, 0, 16, 0, 0);   idle_cycle();
    do_run(1, 0, 7, 0, 0);    idle_cycle();
    do_run(0, 14, 40, 0, 0);
    do_run(0, 5, 0, 0, 1);    idle_cycle();
    do_illegal(9, 12);
    do_run(2, 7, 20, 1, 0);
    do_run(1, 3, 5, 0, 1);    idle_cycle();

    // Asynchronous reset between edges in the middle of a run.
    send_cmd(0, 3, 30, waited);
    repeat (5) begin @(posedge CLK); #1; end
    #2 RESET_L = 1'b0;
    #1;
    check("mid_rst_enb", 32'(ENB), 32'd0);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_ready", 32'(CMD_READY), 32'd0);
    check("mid_rst_state", 32'(STATE), 32'(ST_IDLE));
    #3 RESET_L = 1'b1;
    @(posedge CLK); #1;
    check("mid_rel_ready", 32'(CMD_READY), 32'd1);
    check("mid_rel_done", 32'(DONE), 32'd0);
    check("mid_rel_wraps", 32'(WRAPS), 32'd0);
    last_res = '0;

    for (int i = 0; i < 14; i++) begin
      mode = $urandom_range(0, 3);
      if (mode == 3) begin
        do_illegal($urandom_range(0, 15), $urandom_range(0, 255));
      end else begin
        do_run(mode, $urandom_range(0, 15), $urandom_range(0, 45),
               1'($urandom_range(0, 1)), 0);
        if ($urandom_range(0, 1) == 1) idle_cycle();
      end
    end
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
